// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA IO bus arbiter.
package io_bus_arbiter_pkg;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int ADDR_W          = 30;
  localparam int DATA_W          = 32;
  localparam int BE_W            = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Requester ids; also the bit index of each port in req/gnt vectors
  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  // Latched bus command of the granted requester
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } bus_cmd_t;

  function automatic bus_cmd_t make_cmd(input logic              we,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata,
                                        input logic [BE_W-1:0]   be);
    bus_cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    c.be    = be;
    return c;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that was not served last wins.
module rr_arbiter2
  import io_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Combinational grant; bit 0 is the CPU, bit 1 the DMA
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == OWNER_DMA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates a CPU data port and a DMA port onto a single IO bus.
// One transaction in flight at a time: grant, one-cycle bus_req pulse,
// wait for bus_ack (bounded by TIMEOUT), then a one-cycle done to the owner.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic              cpu_flush,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_stall,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [BE_W-1:0]   dma_be,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  // IO bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [BE_W-1:0]   bus_be,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e         state;
  owner_e         owner;
  owner_e         last_grant;
  logic [CNT_W-1:0] cnt;
  bus_cmd_t       cmd;

  logic [1:0]     pend;
  logic [1:0]     gnt;
  bus_cmd_t       cpu_cmd;
  bus_cmd_t       dma_cmd;

  // A flushed CPU request is withdrawn before it can win this cycle
  assign pend[OWNER_CPU] = cpu_req & ~cpu_flush;
  assign pend[OWNER_DMA] = dma_req;

  assign cpu_cmd = make_cmd(cpu_we, cpu_addr, cpu_wdata, cpu_be);
  assign dma_cmd = make_cmd(dma_we, dma_addr, dma_wdata, dma_be);

  rr_arbiter2 u_rr (
    .req  (pend),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Bus fields come straight from the latched command so they stay stable
  // for the whole transaction.
  assign bus_we    = cmd.we;
  assign bus_addr  = cmd.addr;
  assign bus_wdata = cmd.wdata;
  assign bus_be    = cmd.be;

  // The CPU Mem stage freezes until its own done arrives
  assign cpu_stall = cpu_req & ~cpu_done;

  // Arbitration FSM with registered bus_req, done, err and rdata outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWNER_CPU;
      last_grant <= OWNER_DMA;
      cnt        <= '0;
      cmd        <= '0;
      bus_req    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      dma_done   <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle
      bus_req  <= 1'b0;
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      dma_done <= 1'b0;
      dma_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            owner   <= gnt[OWNER_DMA] ? OWNER_DMA : OWNER_CPU;
            cmd     <= gnt[OWNER_DMA] ? dma_cmd : cpu_cmd;
            bus_req <= 1'b1;
            state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // Ack wins over the timeout when both land on the last WAIT cycle
          if (bus_ack || cnt == CNT_LAST) begin
            state <= ST_RESP;
            if (owner == OWNER_CPU) begin
              cpu_done  <= 1'b1;
              cpu_err   <= ~bus_ack;
              cpu_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              dma_done  <= 1'b1;
              dma_err   <= ~bus_ack;
              dma_rdata <= bus_ack ? bus_rdata : '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of cycles waited for bus_ack before an error completion.
REQ-002 SHALL have ports clk (input, 1) and reset (input, 1): reset reset, synchronous, active-high; clock clk.
REQ-003 cpu_req in 1; cpu_we in 1; cpu_addr in 30 (word address [31:2]); cpu_wdata in 32; cpu_be in 4; cpu_flush in 1 (pipeline exception cancels a pending CPU request).
REQ-004 cpu_done out 1; cpu_rdata out 32; cpu_err out 1; cpu_stall out 1 (freezes the pipeline Mem stage).
REQ-005 dma_req in 1; dma_we in 1; dma_addr in 30; dma_wdata in 32; dma_be in 4; dma_done out 1; dma_rdata out 32; dma_err out 1.
REQ-006 bus_req out 1; bus_we out 1; bus_addr out 30; bus_wdata out 32; bus_be out 4; bus_ack in 1; bus_rdata in 32.

Function
REQ-007 SHALL use an FSM with states IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE: a request is pending when its req is high; with one pending, grant it; with both pending, grant round-robin by last_grant (grant the port not served last); go to ISSUE on the next edge.
REQ-009 On grant, SHALL latch we/addr/wdata/be of the winner and the owner id; requester signals are ignored until done.
REQ-010 ISSUE: bus_req=1 for exactly one cycle with the latched fields, then go to WAIT with timeout counter cleared to 0.
REQ-011 WAIT: bus_* fields held stable, bus_req=0; on bus_ack latch bus_rdata and go to RESP with err=0; else increment counter; at counter==TIMEOUT-1 with no ack go to RESP with err=1 and rdata=32'h0.
REQ-012 bus_ack seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-013 RESP: owner's done=1 for one cycle, with its rdata and err valid in that cycle; update last_grant to the owner; return to IDLE.
REQ-014 Total latency from grant to done SHALL be 3+k cycles, where bus_ack arrives k cycles after entering WAIT (k=0 means ack in the first WAIT cycle).
REQ-015 Non-owner done/err SHALL be 0; rdata of both ports SHALL hold the last completed value of that port.
REQ-016 cpu_stall = cpu_req & ~cpu_done (combinational), so a CPU access blocked by a DMA transaction stalls.
REQ-017 cpu_flush with a CPU request not yet granted: in the same cycle, suppress the CPU grant (the DMA may still be granted). A granted CPU transaction SHALL run to completion, with its done still reported.
REQ-018 A write (we=1) SHALL complete identically to a read; rdata is then don't-care but is still latched.
REQ-019 Simultaneous requests in the cycle the arbiter returns to IDLE SHALL be arbitrated in that IDLE cycle, with no extra bubble.

Reset
REQ-020 On reset: state=IDLE, last_grant=DMA (CPU wins the first tie), counter=0, owner=CPU, all done/err/bus_req/bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, cpu_rdata=dma_rdata=0.
REQ-021 Reset mid-transaction SHALL abandon it with no done pulse; an ack arriving afterwards is ignored per REQ-012.

Structure
REQ-022 State encoding, the owner-id constants (CPU=0, DMA=1) and the TIMEOUT default SHALL live in the shared CPU parameter include.
REQ-023 The round-robin pick SHALL be one sub-module, rr_arbiter2 (inputs req[1:0], last; output gnt[1:0]); the rest is flat.

Verification
REQ-024 CPU read only, addr=30'h1FC0, ack k=2 with rdata=32'hDEADBEEF -> cpu_done 5 cycles after grant, cpu_rdata=DEADBEEF, cpu_err=0, cpu_stall high until done.
REQ-025 Both requesting from reset -> CPU served first, DMA second; repeated dual requests alternate CPU/DMA/CPU.
REQ-026 No ack, TIMEOUT=16 -> done with err=1 and rdata=0 exactly 16 WAIT cycles later; a late ack is ignored.
REQ-027 DMA in WAIT, CPU req + cpu_flush -> CPU never granted, no cpu_done; DMA completes normally.
REQ-028 Reset asserted in WAIT, ack next cycle -> no done pulse, FSM stays IDLE, all outputs at reset values.
